mul_div_unit: RTL and testbench

- Multi-cycle integer multiply/divide unit for the pipelined MIPS CPU; executes MULT, MULTU, DIV and DIVU.
- Sits beside the single-cycle ALU in EX and owns the architectural HI/LO registers.
- The pipeline stalls on busy_o and reads HI/LO (MFHI/MFLO) from hi_o/lo_o.
- Radix-2 iterative: shift-add multiplier, restoring divider, one result bit per cycle.

---
 rtl/mul_div_unit.sv | 172 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Radix-2 iterative multiply/divide unit owning the MIPS HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign-corrected in a final cycle.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             cancel_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t               state_r, state_nx_s;
  logic [CNT_W-1:0]     cnt_r;
  logic                 op_div_r, neg_q_r, neg_rem_r, divz_r;
  logic [WIDTH-1:0]     a_r;
  logic [2*WIDTH-1:0]   p_r;
  logic [WIDTH-1:0]     hi_r, lo_r;
  logic                 busy_r, done_r;

  logic                 start_ok_s, mt_ok_s, commit_s;
  logic                 sgn_s, neg1_s, neg2_s;
  logic [WIDTH-1:0]     abs1_s, abs2_s;
  logic [WIDTH:0]       mul_sum_s, div_trial_s, div_diff_s;
  logic                 div_ge_s;
  logic [WIDTH-1:0]     div_rem_s;
  logic [2*WIDTH-1:0]   step_s, prod_fix_s;
  logic [WIDTH-1:0]     q_s, r_s, fix_hi_s, fix_lo_s;

  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

  // Control qualifiers: cancel beats start, start beats MTHI/MTLO
  always_comb begin
    start_ok_s = (state_r == IDLE) && start_i && !cancel_i;
    mt_ok_s    = (state_r == IDLE) && !start_i;
    commit_s   = (state_r == FIX) && !cancel_i;
  end

  // Operand magnitudes for the signed variants (op_i[0]==0)
  always_comb begin
    sgn_s  = ~op_i[0];
    neg1_s = sgn_s & src1_i[WIDTH-1];
    neg2_s = sgn_s & src2_i[WIDTH-1];
    abs1_s = neg1_s ? (~src1_i + ONE_W) : src1_i;
    abs2_s = neg2_s ? (~src2_i + ONE_W) : src2_i;
  end

  // One radix-2 iteration; p_r holds {acc/rem, multiplier/dividend+quotient}
  always_comb begin
    mul_sum_s   = {1'b0, p_r[2*WIDTH-1:WIDTH]} + (p_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
    div_trial_s = p_r[2*WIDTH-1:WIDTH-1];
    div_ge_s    = (div_trial_s >= {1'b0, a_r});
    div_diff_s  = div_trial_s - {1'b0, a_r};
    div_rem_s   = div_ge_s ? div_diff_s[WIDTH-1:0] : div_trial_s[WIDTH-1:0];
    step_s      = op_div_r ? {div_rem_s, p_r[WIDTH-2:0], div_ge_s}
                           : {mul_sum_s, p_r[WIDTH-1:1]};
  end

  // Sign correction; a zero divisor forces LO to all ones, HI regains the dividend
  always_comb begin
    prod_fix_s = neg_q_r ? (~p_r + ONE_2W) : p_r;
    q_s        = p_r[WIDTH-1:0];
    r_s        = p_r[2*WIDTH-1:WIDTH];
    if (op_div_r) begin
      fix_lo_s = divz_r ? {WIDTH{1'b1}} : (neg_q_r ? (~q_s + ONE_W) : q_s);
      fix_hi_s = neg_rem_r ? (~r_s + ONE_W) : r_s;
    end else begin
      fix_lo_s = prod_fix_s[WIDTH-1:0];
      fix_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) state_nx_s = CALC;
        else            state_nx_s = IDLE;
      end
      CALC: begin
        if (cancel_i)                     state_nx_s = IDLE;
        else if (cnt_r == {CNT_W{1'b1}})  state_nx_s = FIX;
        else                              state_nx_s = CALC;
      end
      FIX:     state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_r <= IDLE;
    else        state_r <= state_nx_s;
  end

  // Operand latch and iterative datapath
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_r     <= {CNT_W{1'b0}};
      op_div_r  <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      divz_r    <= 1'b0;
      a_r       <= {WIDTH{1'b0}};
      p_r       <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            cnt_r     <= {CNT_W{1'b0}};
            op_div_r  <= op_i[1];
            neg_q_r   <= neg1_s ^ neg2_s;
            neg_rem_r <= neg1_s;
            divz_r    <= (src2_i == {WIDTH{1'b0}});
            a_r       <= op_i[1] ? abs2_s : abs1_s;
            p_r       <= {{WIDTH{1'b0}}, (op_i[1] ? abs1_s : abs2_s)};
          end
        end
        CALC: begin
          p_r   <= step_s;
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        default: ;
      endcase
    end
  end

  // Architectural HI/LO: results on commit, MTHI/MTLO only when idle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else if (commit_s) begin
      hi_r <= fix_hi_s;
      lo_r <= fix_lo_s;
    end else if (mt_ok_s) begin
      if (hi_we_i) hi_r <= wdata_i;
      if (lo_we_i) lo_r <= wdata_i;
    end
  end

  // Registered status flags
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nx_s != IDLE);
      done_r <= commit_s;
    end
  end

  assign hi_o   = hi_r;
  assign lo_o   = lo_r;
  assign busy_o = busy_r;
  assign done_o = done_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized self-checking bench for mul_div_unit against a plain-arithmetic HI/LO model.
module tb_mul_div_unit;

  logic        clk_i = 1'b0, rst_i = 1'b0, start_i = 1'b0, cancel_i = 1'b0;
  logic        hi_we_i = 1'b0, lo_we_i = 1'b0;
  logic [1:0]  op_i = 2'd0;
  logic [31:0] src1_i = 32'd0, src2_i = 32'd0, wdata_i = 32'd0;
  logic [31:0] hi_o, lo_o;
  logic        busy_o, done_o;

  int          checks = 0, errors = 0;
  logic [31:0] exp_hi = 32'd0, exp_lo = 32'd0;

  mul_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .src1_i(src1_i), .src2_i(src2_i), .cancel_i(cancel_i),
    .hi_we_i(hi_we_i), .lo_we_i(lo_we_i), .wdata_i(wdata_i),
    .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference {HI,LO} from the MIPS arithmetic rules
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int    sa, sb, q, r;
    longint p;
    sa = a;
    sb = b;
    case (op)
      2'd0: begin
        p = longint'(sa) * longint'(sb);
        return p;
      end
      2'd1: return {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Launch an op (with a random MT write that must lose to start), optionally
  // inject an ignored start/MTHI/MTLO while busy, then check latency and result
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj_at, input string tag);
    logic [63:0] e;
    logic [31:0] h0, l0;
    int done_at, busy_cnt;
    h0 = exp_hi;
    l0 = exp_lo;
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; src1_i = a; src2_i = b;
    hi_we_i = 1'($urandom); lo_we_i = 1'($urandom); wdata_i = $urandom;
    @(negedge clk_i);
    done_at = -1;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      start_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
      if (done_o) begin
        done_at = i;
        break;
      end
      if (busy_o) busy_cnt++;
      if (i == 16) begin
        check_eq({tag, " hold_hi"}, 64'(hi_o), 64'(h0));
        check_eq({tag, " hold_lo"}, 64'(lo_o), 64'(l0));
      end
      if (i == inj_at) begin
        start_i = 1'b1; op_i = 2'($urandom); src1_i = $urandom; src2_i = $urandom;
        hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = $urandom;
      end
      @(negedge clk_i);
    end
    e = ref_result(op, a, b);
    exp_hi = e[63:32];
    exp_lo = e[31:0];
    check_eq({tag, " latency"}, 64'(done_at), 64'd33);
    check_eq({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    check_eq({tag, " busy_in_done"}, 64'(busy_o), 64'd0);
    check_eq({tag, " hi"}, 64'(hi_o), 64'(exp_hi));
    check_eq({tag, " lo"}, 64'(lo_o), 64'(exp_lo));
    @(negedge clk_i);
    check_eq({tag, " done_pulse"}, 64'(done_o), 64'd0);
    check_eq({tag, " busy_after"}, 64'(busy_o), 64'd0);
  endtask

  // Watch for spurious done pulses over a window
  task automatic no_done(input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) seen++;
      @(negedge clk_i);
    end
    check_eq({tag, " no_done"}, 64'(seen), 64'd0);
    check_eq({tag, " hi_kept"}, 64'(hi_o), 64'(exp_hi));
    check_eq({tag, " lo_kept"}, 64'(lo_o), 64'(exp_lo));
  endtask

  task automatic run_cancel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int at, input string tag);
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; src1_i = a; src2_i = b;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < at; i++) @(negedge clk_i);
    check_eq({tag, " busy_before"}, 64'(busy_o), 64'd1);
    cancel_i = 1'b1;
    @(negedge clk_i);
    cancel_i = 1'b0;
    check_eq({tag, " busy_drop"}, 64'(busy_o), 64'd0);
    no_done(tag);
  endtask

  task automatic mt(input logic hw, input logic lw, input logic [31:0] d, input string tag);
    @(negedge clk_i);
    hi_we_i = hw; lo_we_i = lw; wdata_i = d;
    @(negedge clk_i);
    hi_we_i = 1'b0; lo_we_i = 1'b0;
    if (hw) exp_hi = d;
    if (lw) exp_lo = d;
    check_eq({tag, " hi"}, 64'(hi_o), 64'(exp_hi));
    check_eq({tag, " lo"}, 64'(lo_o), 64'(exp_lo));
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    repeat (2) @(negedge clk_i);
    check_eq("rst hi", 64'(hi_o), 64'd0);
    check_eq("rst lo", 64'(lo_o), 64'd0);
    check_eq("rst busy", 64'(busy_o), 64'd0);
    check_eq("rst done", 64'(done_o), 64'd0);
    rst_i = 1'b1;

    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, "multu_max");
    run_op(2'd0, 32'hFFFFFFF9, 32'd3, -1, "mult_neg");
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, -1, "div_neg");
    run_op(2'd3, 32'd100, 32'd7, -1, "divu");
    run_op(2'd3, 32'd5, 32'd0, -1, "divu_zero");
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, -1, "div_ovf");
    run_op(2'd2, 32'hFFFFFFF9, 32'd0, -1, "div_zero_neg");
    run_op(2'd0, 32'h80000000, 32'h80000000, -1, "mult_minmin");
    run_op(2'd0, 32'd3, 32'd4, 10, "mult_inject");
    run_op(2'd1, 32'd2, 32'd3, -1, "multu_small");
    run_cancel(2'd3, 32'd1000, 32'd7, 15, "cancel");
    mt(1'b1, 1'b0, 32'h0000DEAD, "mthi");
    mt(1'b0, 1'b1, 32'h0000BEEF, "mtlo");
    mt(1'b1, 1'b1, 32'h12345678, "mt_both");

    // start together with cancel in IDLE is dropped
    @(negedge clk_i);
    start_i = 1'b1; cancel_i = 1'b1; op_i = 2'd1; src1_i = 32'd9; src2_i = 32'd9;
    @(negedge clk_i);
    start_i = 1'b0; cancel_i = 1'b0;
    check_eq("idle_cancel busy", 64'(busy_o), 64'd0);
    no_done("idle_cancel");

    for (int n = 0; n < 30; n++) begin
      rop = 2'($urandom);
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFFFFFF - 32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, (n % 3 == 0) ? 20 : -1, "rand");
    end

    // asynchronous reset mid-divide
    mt(1'b1, 1'b1, 32'hCAFEF00D, "pre_rst");
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'd2; src1_i = 32'h7FFF0000; src2_i = 32'd13;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (19) @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    check_eq("async_rst busy", 64'(busy_o), 64'd0);
    check_eq("async_rst done", 64'(done_o), 64'd0);
    check_eq("async_rst hi", 64'(hi_o), 64'd0);
    check_eq("async_rst lo", 64'(lo_o), 64'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    @(negedge clk_i);
    rst_i = 1'b1;
    no_done("post_rst");
    run_op(2'd3, 32'd9, 32'd3, -1, "divu_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
